port_c_hs: RTL and testbench

- Parametrised successor to the combinational Port C nibble logic.
- Registered, WIDTH-bit Port C with:
  - a CPU-writable output latch;
  - Bit Set/Reset (BSR) on single bits;
  - a direction bit per GROUP_W-bit group;
  - an optional strobed-input handshake (mode-1 style: STB/IBF/INTR/INTE) that captures Port A data.
- Sits between the control-word decoder and the pad ring. The top level builds the inout pins from pc_out/pc_oe.

---
 rtl/port_c_hs.sv | 155 +++++++++++++++
 tb/tb_port_c_hs.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_c_hs.sv
// Registered Port C: CPU output latch with bit set/reset, per-group direction,
// and an optional strobed-input handshake that captures Port A data.
module port_c_hs #(
  parameter int WIDTH    = 8,
  parameter int GROUP_W  = 4,
  parameter int STB_BIT  = 4,
  parameter int IBF_BIT  = 5,
  parameter int INTR_BIT = 3,
  localparam int NGROUPS = WIDTH / GROUP_W,
  localparam int BW      = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               bsr_en,
  input  logic [BW-1:0]      bsr_bit,
  input  logic               bsr_val,
  input  logic [NGROUPS-1:0] dir,
  input  logic               hs_mode,
  input  logic               rd_strobe,
  input  logic [WIDTH-1:0]   pc_in,
  input  logic [WIDTH-1:0]   pa_in,
  output logic [WIDTH-1:0]   pc_out,
  output logic [WIDTH-1:0]   pc_oe,
  output logic [WIDTH-1:0]   pc_rd_data,
  output logic [WIDTH-1:0]   pa_latch,
  output logic               overrun
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_FULL} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_latch;
  logic [WIDTH-1:0] r_pa_latch;
  logic             r_ibf, r_intr, r_inte, r_overrun, r_no_int;
  logic             r_stb_s0, r_stb_s1, r_stb_prev;

  logic             w_bsr_valid, w_bsr_is_stb, w_bsr_inte, w_bsr_latch;
  logic             w_inte_next, w_fall, w_rise;
  logic [WIDTH-1:0] w_oe_base, w_rd_base;

  assign w_bsr_valid  = ({1'b0, bsr_bit} < (BW+1)'(WIDTH));
  assign w_bsr_is_stb = (bsr_bit == BW'(STB_BIT));
  // In handshake mode a BSR aimed at the STB bit programs INTE, not the latch.
  assign w_bsr_inte   = bsr_en & ~wr_en & hs_mode & w_bsr_valid & w_bsr_is_stb;
  assign w_bsr_latch  = bsr_en & w_bsr_valid & ~(hs_mode & w_bsr_is_stb);
  assign w_inte_next  = w_bsr_inte ? bsr_val : r_inte;

  assign w_fall = r_stb_prev & ~r_stb_s1;
  assign w_rise = ~r_stb_prev & r_stb_s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_latch    <= '0;
      r_pa_latch <= '0;
      r_ibf      <= 1'b0;
      r_intr     <= 1'b0;
      r_inte     <= 1'b0;
      r_overrun  <= 1'b0;
      r_no_int   <= 1'b0;
      r_stb_s0   <= 1'b1;
      r_stb_s1   <= 1'b1;
      r_stb_prev <= 1'b1;
    end else begin
      r_stb_s0   <= pc_in[STB_BIT];
      r_stb_s1   <= r_stb_s0;
      r_stb_prev <= r_stb_s1;

      if (wr_en)
        r_latch <= wr_data;
      else if (w_bsr_latch)
        r_latch[bsr_bit] <= bsr_val;

      if (!hs_mode) begin
        r_state   <= S_IDLE;
        r_ibf     <= 1'b0;
        r_intr    <= 1'b0;
        r_inte    <= 1'b0;
        r_overrun <= 1'b0;
        r_no_int  <= 1'b0;
      end else begin
        if (w_bsr_inte)
          r_inte <= bsr_val;
        if (w_fall && r_state != S_IDLE)
          r_overrun <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_fall) begin
              r_pa_latch <= pa_in;
              r_ibf      <= 1'b1;
              r_no_int   <= 1'b0;
              r_state    <= S_LOW;
            end
          end
          S_LOW: begin
            // A read taken before the strobe ends suppresses the interrupt.
            if (w_rise) begin
              r_no_int <= 1'b0;
              if (r_no_int || rd_strobe) begin
                r_ibf   <= 1'b0;
                r_intr  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_intr  <= w_inte_next;
                r_state <= S_FULL;
              end
            end else if (rd_strobe) begin
              r_ibf    <= 1'b0;
              r_no_int <= 1'b1;
            end
          end
          S_FULL: begin
            if (rd_strobe) begin
              r_ibf   <= 1'b0;
              r_intr  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_intr <= w_inte_next;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_oe_base[gi] = ~dir[gi / GROUP_W];
      assign w_rd_base[gi] = w_oe_base[gi] ? r_latch[gi] : pc_in[gi];
    end
  endgenerate

  always_comb begin
    pc_oe      = w_oe_base;
    pc_out     = r_latch;
    pc_rd_data = w_rd_base;
    if (hs_mode) begin
      pc_oe[STB_BIT]       = 1'b0;
      pc_oe[IBF_BIT]       = 1'b1;
      pc_oe[INTR_BIT]      = 1'b1;
      pc_out[IBF_BIT]      = r_ibf;
      pc_out[INTR_BIT]     = r_intr;
      pc_rd_data[STB_BIT]  = r_inte;
      pc_rd_data[IBF_BIT]  = r_ibf;
      pc_rd_data[INTR_BIT] = r_intr;
    end
  end

  assign pa_latch = r_pa_latch;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_port_c_hs.sv
// Self-checking bench for port_c_hs: latch writes, BSR, direction, strobed
// handshake, overrun and asynchronous reset, with a queue of expected values.
module tb_port_c_hs;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       bsr_en;
  logic [2:0] bsr_bit;
  logic       bsr_val;
  logic [1:0] dir;
  logic       hs_mode;
  logic       rd_strobe;
  logic [7:0] pc_in;
  logic [7:0] pa_in;
  logic [7:0] pc_out;
  logic [7:0] pc_oe;
  logic [7:0] pc_rd_data;
  logic [7:0] pa_latch;
  logic       overrun;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] sbq[$];
  logic [7:0] m_latch;

  port_c_hs #(.WIDTH(8), .GROUP_W(4), .STB_BIT(4), .IBF_BIT(5), .INTR_BIT(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .bsr_en(bsr_en), .bsr_bit(bsr_bit), .bsr_val(bsr_val), .dir(dir),
    .hs_mode(hs_mode), .rd_strobe(rd_strobe), .pc_in(pc_in), .pa_in(pa_in),
    .pc_out(pc_out), .pc_oe(pc_oe), .pc_rd_data(pc_rd_data),
    .pa_latch(pa_latch), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_bsr(input logic [2:0] b, input logic v);
    bsr_en  = 1'b1;
    bsr_bit = b;
    bsr_val = v;
    tick();
    bsr_en  = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'hA5; dir = 2'b00;
    bsr_en = 1'b0; bsr_bit = 3'd0; bsr_val = 1'b0; hs_mode = 1'b0;
    rd_strobe = 1'b0; pc_in = 8'hFF; pa_in = 8'h00;
    repeat (2) tick();
    n_total++;
    if (pc_out !== 8'h00) $display("FAIL reset_pc_out: got %h expected %h", pc_out, 8'h00); else n_pass++;
    n_total++;
    if (pa_latch !== 8'h00) $display("FAIL reset_pa_latch: got %h expected %h", pa_latch, 8'h00); else n_pass++;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
    sbq.push_back(8'hA5);
    reset = 1'b0;
    tick();
    wr_en = 1'b0;
    exp = sbq.pop_front();
    m_latch = exp;
    n_total++;
    if (pc_out !== exp) $display("FAIL release_pc_out: got %h expected %h", pc_out, exp); else n_pass++;
    n_total++;
    if (pc_oe !== 8'hFF) $display("FAIL release_pc_oe: got %h expected %h", pc_oe, 8'hFF); else n_pass++;
    $display("txn reset: pc_out=%h pc_oe=%h", pc_out, pc_oe);
  endtask

  task automatic test_latch_bsr();
    logic [7:0] exp;
    dir = 2'b10;
    wr_en = 1'b1; wr_data = 8'h3C; sbq.push_back(8'h3C);
    tick();
    wr_en = 1'b0;
    exp = sbq.pop_front();
    n_total++;
    if (pc_out !== exp) $display("FAIL wr_3c: got %h expected %h", pc_out, exp); else n_pass++;
    sbq.push_back(8'hBC);
    do_bsr(3'd7, 1'b1);
    exp = sbq.pop_front();
    n_total++;
    if (pc_out !== exp) $display("FAIL bsr7: got %h expected %h", pc_out, exp); else n_pass++;
    sbq.push_back(8'hBD);
    do_bsr(3'd0, 1'b1);
    exp = sbq.pop_front();
    n_total++;
    if (pc_out !== exp) $display("FAIL bsr0: got %h expected %h", pc_out, exp); else n_pass++;
    n_total++;
    if (pc_oe !== 8'h0F) $display("FAIL dir_pc_oe: got %h expected %h", pc_oe, 8'h0F); else n_pass++;
    pc_in = 8'h96;
    #1;
    n_total++;
    if (pc_rd_data !== 8'h9D) $display("FAIL readback_mix: got %h expected %h", pc_rd_data, 8'h9D); else n_pass++;
    wr_en = 1'b1; wr_data = 8'h00; bsr_en = 1'b1; bsr_bit = 3'd2; bsr_val = 1'b1;
    sbq.push_back(8'h00);
    tick();
    wr_en = 1'b0; bsr_en = 1'b0;
    exp = sbq.pop_front();
    n_total++;
    if (pc_out !== exp) $display("FAIL wr_beats_bsr: got %h expected %h", pc_out, exp); else n_pass++;
    sbq.push_back(8'h10);
    do_bsr(3'd4, 1'b1);
    exp = sbq.pop_front();
    m_latch = exp;
    n_total++;
    if (pc_out !== exp) $display("FAIL bsr4_plain: got %h expected %h", pc_out, exp); else n_pass++;
    $display("txn latch_bsr: pc_out=%h pc_oe=%h rd=%h", pc_out, pc_oe, pc_rd_data);
  endtask

  task automatic test_handshake(input logic inte_val, input logic [7:0] pa);
    logic [7:0] exp;
    int cnt;
    logic intr_seen;
    dir = 2'b00; pc_in = 8'hFF; hs_mode = 1'b1;
    tick();
    do_bsr(3'd4, inte_val);
    n_total++;
    if (pc_rd_data[4] !== inte_val) $display("FAIL hs_inte_rd: got %b expected %b", pc_rd_data[4], inte_val); else n_pass++;
    n_total++;
    if (pc_oe !== 8'hEF) $display("FAIL hs_pc_oe: got %h expected %h", pc_oe, 8'hEF); else n_pass++;
    pa_in = pa;
    sbq.push_back(pa);
    pc_in[4] = 1'b0;
    cnt = 0;
    intr_seen = 1'b0;
    while (pc_out[5] !== 1'b1 && cnt < 6) begin
      tick();
      cnt++;
      intr_seen = intr_seen | pc_out[3];
    end
    n_total++;
    if (cnt > 3) $display("FAIL hs_ibf_latency: got %0d cycles expected <=3", cnt); else n_pass++;
    pa_in = ~pa;
    exp = sbq.pop_front();
    n_total++;
    if (pa_latch !== exp) $display("FAIL hs_pa_latch: got %h expected %h", pa_latch, exp); else n_pass++;
    repeat (2) begin
      tick();
      intr_seen = intr_seen | pc_out[3];
    end
    n_total++;
    if (pa_latch !== exp) $display("FAIL hs_pa_hold: got %h expected %h", pa_latch, exp); else n_pass++;
    pc_in[4] = 1'b1;
    cnt = 0;
    if (inte_val) begin
      while (pc_out[3] !== 1'b1 && cnt < 6) begin
        tick();
        cnt++;
      end
      n_total++;
      if (cnt > 3) $display("FAIL hs_intr_latency: got %0d cycles expected <=3", cnt); else n_pass++;
    end else begin
      repeat (5) begin
        tick();
        intr_seen = intr_seen | pc_out[3];
      end
      n_total++;
      if (intr_seen !== 1'b0) $display("FAIL hs_intr_masked: got %b expected 0", intr_seen); else n_pass++;
      n_total++;
      if (pc_out[5] !== 1'b1) $display("FAIL hs_ibf_held: got %b expected 1", pc_out[5]); else n_pass++;
    end
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    n_total++;
    if (pc_out[5] !== 1'b0) $display("FAIL hs_rd_ibf: got %b expected 0", pc_out[5]); else n_pass++;
    n_total++;
    if (pc_out[3] !== 1'b0) $display("FAIL hs_rd_intr: got %b expected 0", pc_out[3]); else n_pass++;
    hs_mode = 1'b0;
    tick();
    n_total++;
    if (pc_out !== m_latch) $display("FAIL hs_latch_kept: got %h expected %h", pc_out, m_latch); else n_pass++;
    $display("txn handshake inte=%b: pa_latch=%h pc_out=%h", inte_val, pa_latch, pc_out);
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    int cnt;
    hs_mode = 1'b1; pc_in = 8'hFF;
    tick();
    do_bsr(3'd4, 1'b1);
    pa_in = 8'h5A;
    sbq.push_back(8'h5A);
    pc_in[4] = 1'b0;
    repeat (5) tick();
    exp = sbq.pop_front();
    n_total++;
    if (pa_latch !== exp) $display("FAIL ov_first_capture: got %h expected %h", pa_latch, exp); else n_pass++;
    pc_in[4] = 1'b1;
    cnt = 0;
    while (pc_out[3] !== 1'b1 && cnt < 6) begin
      tick();
      cnt++;
    end
    n_total++;
    if (cnt > 3) $display("FAIL ov_intr_latency: got %0d cycles expected <=3", cnt); else n_pass++;
    do_bsr(3'd4, 1'b0);
    n_total++;
    if (pc_out[3] !== 1'b0) $display("FAIL full_inte_clr: got %b expected 0", pc_out[3]); else n_pass++;
    do_bsr(3'd4, 1'b1);
    n_total++;
    if (pc_out[3] !== 1'b1) $display("FAIL full_inte_set: got %b expected 1", pc_out[3]); else n_pass++;
    pa_in = 8'hFF;
    pc_in[4] = 1'b0;
    repeat (5) tick();
    n_total++;
    if (overrun !== 1'b1) $display("FAIL ov_set: got %b expected 1", overrun); else n_pass++;
    n_total++;
    if (pa_latch !== exp) $display("FAIL ov_no_overwrite: got %h expected %h", pa_latch, exp); else n_pass++;
    pc_in[4] = 1'b1;
    repeat (4) tick();
    hs_mode = 1'b0;
    tick();
    n_total++;
    if (overrun !== 1'b0) $display("FAIL ov_clear: got %b expected 0", overrun); else n_pass++;
    hs_mode = 1'b1;
    #1;
    n_total++;
    if (pc_rd_data[5] !== 1'b0) $display("FAIL ov_ibf_clear: got %b expected 0", pc_rd_data[5]); else n_pass++;
    n_total++;
    if (pc_rd_data[4] !== 1'b0) $display("FAIL ov_inte_clear: got %b expected 0", pc_rd_data[4]); else n_pass++;
    n_total++;
    if (pa_latch !== exp) $display("FAIL ov_pa_kept: got %h expected %h", pa_latch, exp); else n_pass++;
    $display("txn overrun: overrun=%b pa_latch=%h", overrun, pa_latch);
  endtask

  task automatic test_async_reset();
    tick();
    do_bsr(3'd4, 1'b1);
    pa_in = 8'h33;
    pc_in[4] = 1'b0;
    repeat (5) tick();
    pc_in[4] = 1'b1;
    repeat (5) tick();
    pc_in[4] = 1'b0;
    repeat (5) tick();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    pc_in[4] = 1'b1;
    repeat (5) tick();
    pc_in[4] = 1'b0;
    repeat (5) tick();
    n_total++;
    if (pc_rd_data[5] !== 1'b1) $display("FAIL low_ibf_before: got %b expected 1", pc_rd_data[5]); else n_pass++;
    n_total++;
    if (overrun !== 1'b1) $display("FAIL low_overrun_before: got %b expected 1", overrun); else n_pass++;
    #3;
    reset = 1'b1;
    #1;
    n_total++;
    if (pc_rd_data[5] !== 1'b0) $display("FAIL async_ibf: got %b expected 0", pc_rd_data[5]); else n_pass++;
    n_total++;
    if (pc_out[3] !== 1'b0) $display("FAIL async_intr: got %b expected 0", pc_out[3]); else n_pass++;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL async_overrun: got %b expected 0", overrun); else n_pass++;
    n_total++;
    if (pa_latch !== 8'h00) $display("FAIL async_pa_latch: got %h expected %h", pa_latch, 8'h00); else n_pass++;
    $display("txn async_reset: ibf=%b intr=%b overrun=%b", pc_rd_data[5], pc_out[3], overrun);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latch_bsr();
    test_handshake(1'b1, 8'h5A);
    test_handshake(1'b0, 8'hC3);
    test_overrun();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
